// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction-memory writer. Receives a framed byte stream over a
// valid/ready handshake, packs bytes MSB-first into 32-bit words and writes
// them to consecutive imem addresses starting at 0. The processor is held in
// reset (cpu_hold) until the whole image has been written successfully.
//
// Frame: SYNC_BYTE, count_hi, count_lo, N x 4 payload bytes, [checksum byte]
//
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, a running XOR of all payload bytes is kept. One trailing
//   checksum byte is then required, and a mismatch rejects the frame.
//   When undefined, DONE follows the last data word directly.
//
// Ports:
//   clock         in   system clock, rising edge
//   reset         in   asynchronous, active-high reset
//   byte_data     in   [7:0]  stream byte
//   byte_valid    in   byte_data is valid
//   byte_ready    out  loader accepts the byte (transfer on valid & ready)
//   imem_wr_addr  out  [11:0] imem write address
//   imem_wr_data  out  [31:0] imem write data
//   imem_wr_en    out  one-cycle write strobe
//   cpu_hold      out  processor reset, high while loading or on error
//   load_done     out  sticky, image loaded successfully
//   load_err      out  sticky, frame rejected
//   words_loaded  out  [12:0] number of words written so far
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         MAX_WORDS = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic [11:0] imem_wr_addr,
  output logic [31:0] imem_wr_data,
  output logic        imem_wr_en,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [12:0] words_loaded
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LEN_HI = 3'd1;
  localparam logic [2:0] ST_LEN_LO = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam logic [16:0] MAX_WORDS_W = 17'(MAX_WORDS);

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] asm_q, asm_d;
  logic [11:0] addr_q, addr_d;
  logic [12:0] words_q, words_d;
  logic        byte_ready_q, byte_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [11:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q, load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  xor_q, xor_d;
`endif

  logic        fire_s;
  logic [15:0] len_s;
  logic [31:0] word_s;
  logic [12:0] words_inc_s;
  logic        last_word_s;

  assign fire_s      = byte_valid & byte_ready_q;
  // Complete count as it will be once the low byte is stored.
  assign len_s       = {count_q[15:8], byte_data};
  assign word_s      = {asm_q[23:0], byte_data};
  assign words_inc_s = words_q + 13'd1;
  assign last_word_s = ({3'b000, words_inc_s} == count_q);

  // Next-state and datapath logic for the frame parser.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    asm_d     = asm_q;
    addr_d    = addr_q;
    words_d   = words_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_d     = xor_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // Non-sync bytes are consumed and dropped.
        if (fire_s && (byte_data == SYNC_BYTE)) begin
          state_d = ST_LEN_HI;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_LEN_HI: begin
        if (fire_s) begin
          count_d = {byte_data, count_q[7:0]};
          state_d = ST_LEN_LO;
        end else begin
          state_d = ST_LEN_HI;
        end
      end

      ST_LEN_LO: begin
        if (fire_s) begin
          count_d = len_s;
          idx_d   = 2'd0;
          addr_d  = 12'd0;
          if ((len_s == 16'd0) || ({1'b0, len_s} > MAX_WORDS_W)) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN_LO;
        end
      end

      ST_DATA: begin
        if (fire_s) begin
          asm_d = word_s;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ byte_data;
`endif
          if (idx_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = word_s;
            // Wraps to 0 only after word 4096, which is legal.
            addr_d    = addr_q + 12'd1;
            words_d   = words_inc_s;
            idx_d     = 2'd0;
            if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_DONE;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (fire_s) begin
          if (byte_data == xor_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERROR;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
`endif

      ST_DONE:  state_d = ST_DONE;
      ST_ERROR: state_d = ST_ERROR;
      // Any unreachable encoding keeps the processor held.
      default:  state_d = ST_ERROR;
    endcase
  end

  // Status outputs. byte_ready follows the next state so no byte is taken in
  // DONE/ERROR; hold/done/err follow the current state, i.e. one edge after
  // the terminal state is entered, which lets the final write land first.
  always_comb begin
    byte_ready_d = (state_d != ST_DONE) && (state_d != ST_ERROR);
    cpu_hold_d   = (state_q != ST_DONE);
    load_done_d  = load_done_q | (state_q == ST_DONE);
    load_err_d   = load_err_q  | (state_q == ST_ERROR);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      idx_q        <= 2'd0;
      asm_q        <= 32'd0;
      addr_q       <= 12'd0;
      words_q      <= 13'd0;
      byte_ready_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= 12'd0;
      wr_data_q    <= 32'd0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      asm_q        <= asm_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      byte_ready_q <= byte_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q        <= xor_d;
`endif
    end
  end

  assign byte_ready   = byte_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign cpu_hold     = cpu_hold_q;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader: directed test of imem_loader. Works with or without
// IMEM_LOADER_CHECKSUM_EN; checksum-specific steps are compiled accordingly.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic [11:0] imem_wr_addr;
  logic [31:0] imem_wr_data;
  logic        imem_wr_en;
  logic        cpu_hold;
  logic        load_done;
  logic        load_err;
  logic [12:0] words_loaded;

  int total;
  int bad;

  logic [11:0] wa[$];
  logic [31:0] wd[$];

  imem_loader dut (
    .clock        (clock),
    .reset        (reset),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .imem_wr_addr (imem_wr_addr),
    .imem_wr_data (imem_wr_data),
    .imem_wr_en   (imem_wr_en),
    .cpu_hold     (cpu_hold),
    .load_done    (load_done),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Write-strobe monitor, sampled away from the rising edge.
  always @(negedge clock) begin
    if (imem_wr_en === 1'b1) begin
      wa.push_back(imem_wr_addr);
      wd.push_back(imem_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present one byte; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int n;
    n = 0;
    byte_data  = b;
    byte_valid = 1'b1;
    while ((byte_ready !== 1'b1) && (n < 20)) begin
      tick(1);
      n++;
    end
    if (n >= 20) chk("ready_timeout", {31'd0, byte_ready}, 32'd1);
    tick(1);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    if (gap > 0) tick(gap);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    wa.delete();
    wd.delete();
  endtask

  // Sends the two-word reference frame body (without sync/checksum).
  task automatic send_ref_body(input int gap);
    send(8'h00, gap); send(8'h02, gap);
    send(8'h20, gap); send(8'h00, gap); send(8'h00, gap); send(8'h05, gap);
    send(8'h00, gap); send(8'h00, gap); send(8'h00, gap); send(8'h00, gap);
  endtask

  task automatic check_ref_writes(input string tag);
    chk({tag, "_nstrobe"}, 32'(wa.size()), 32'd2);
    if (wa.size() == 2) begin
      chk({tag, "_a0"}, {20'd0, wa[0]}, 32'h0);
      chk({tag, "_d0"}, wd[0], 32'h20000005);
      chk({tag, "_a1"}, {20'd0, wa[1]}, 32'h1);
      chk({tag, "_d1"}, wd[1], 32'h00000000);
    end
  endtask

  logic [7:0] x;

  initial begin
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    tick(2);

    // Reset values while reset is held.
    chk("rst_ready", {31'd0, byte_ready}, 32'd1);
    chk("rst_wr_en", {31'd0, imem_wr_en}, 32'd0);
    chk("rst_addr",  {20'd0, imem_wr_addr}, 32'd0);
    chk("rst_data",  imem_wr_data, 32'd0);
    chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("rst_done",  {31'd0, load_done}, 32'd0);
    chk("rst_err",   {31'd0, load_err}, 32'd0);
    chk("rst_words", {19'd0, words_loaded}, 32'd0);
    reset = 1'b0;
    tick(1);

    // --- Reference frame, back-to-back bytes ---
    send(8'hA5, 0);
    send_ref_body(0);
    chk("t1_wr_en", {31'd0, imem_wr_en}, 32'd1);
    chk("t1_addr",  {20'd0, imem_wr_addr}, 32'd1);
    chk("t1_words", {19'd0, words_loaded}, 32'd2);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t1_hold_pre", {31'd0, cpu_hold}, 32'd1);
    send(8'h25, 0);
    chk("t1_hold_chk", {31'd0, cpu_hold}, 32'd1);
    chk("t1_ready0",   {31'd0, byte_ready}, 32'd0);
`else
    chk("t1_hold_pre", {31'd0, cpu_hold}, 32'd1);
    chk("t1_ready0",   {31'd0, byte_ready}, 32'd0);
`endif
    tick(1);
    chk("t1_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t1_done", {31'd0, load_done}, 32'd1);
    chk("t1_err",  {31'd0, load_err}, 32'd0);
    chk("t1_wr_en_off", {31'd0, imem_wr_en}, 32'd0);
    tick(3);
    check_ref_writes("t1");
    chk("t1_hold_stays", {31'd0, cpu_hold}, 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // --- Same frame with a bad checksum ---
    do_reset();
    send(8'hA5, 0);
    send_ref_body(0);
    send(8'h00, 0);
    tick(1);
    chk("t2_err",   {31'd0, load_err}, 32'd1);
    chk("t2_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t2_done",  {31'd0, load_done}, 32'd0);
    chk("t2_ready", {31'd0, byte_ready}, 32'd0);
    tick(2);
    check_ref_writes("t2");
`endif

    // --- Noise before sync, 3-cycle gaps everywhere ---
    do_reset();
    send(8'h00, 3); send(8'hFF, 3); send(8'h12, 3);
    chk("t3_noise_words", {19'd0, words_loaded}, 32'd0);
    send(8'hA5, 3);
    send_ref_body(3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h25, 3);
`endif
    tick(2);
    chk("t3_done",  {31'd0, load_done}, 32'd1);
    chk("t3_hold",  {31'd0, cpu_hold}, 32'd0);
    chk("t3_words", {19'd0, words_loaded}, 32'd2);
    check_ref_writes("t3");

    // --- Zero count ---
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h00, 0);
    chk("t4_err_early", {31'd0, load_err}, 32'd0);
    chk("t4_ready",     {31'd0, byte_ready}, 32'd0);
    tick(1);
    chk("t4_err",  {31'd0, load_err}, 32'd1);
    chk("t4_hold", {31'd0, cpu_hold}, 32'd1);
    tick(2);
    chk("t4_nstrobe", 32'(wa.size()), 32'd0);

    // --- Oversize count 0x1001 ---
    do_reset();
    send(8'hA5, 0); send(8'h10, 0); send(8'h01, 0);
    tick(1);
    chk("t5_err",  {31'd0, load_err}, 32'd1);
    chk("t5_done", {31'd0, load_done}, 32'd0);
    tick(2);
    chk("t5_nstrobe", 32'(wa.size()), 32'd0);

    // --- Full 4096-word image; word i carries value i ---
    do_reset();
    x = 8'h00;
    send(8'hA5, 0); send(8'h10, 0); send(8'h00, 0);
    for (int i = 0; i < 4096; i++) begin
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'(i >> 8), 0);
      send(8'(i), 0);
      x = x ^ 8'(i >> 8) ^ 8'(i);
    end
    chk("t6_last_addr", {20'd0, imem_wr_addr}, 32'hFFF);
    chk("t6_last_data", imem_wr_data, 32'h00000FFF);
    chk("t6_words", {19'd0, words_loaded}, 32'd4096);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(x, 0);
`endif
    tick(2);
    chk("t6_done", {31'd0, load_done}, 32'd1);
    chk("t6_hold", {31'd0, cpu_hold}, 32'd0);
    chk("t6_nstrobe", 32'(wa.size()), 32'd4096);
    if (wa.size() == 4096) begin
      chk("t6_q_first", {20'd0, wa[0]}, 32'h000);
      chk("t6_q_mid",   wd[1234], 32'd1234);
      chk("t6_q_last",  {20'd0, wa[4095]}, 32'hFFF);
    end

    // --- Asynchronous reset mid-frame (after 2nd byte of word 1) ---
    do_reset();
    send(8'hA5, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h20, 0); send(8'h00, 0); send(8'h00, 0); send(8'h05, 0);
    send(8'h00, 0); send(8'h00, 0);
    chk("t7_pre_words", {19'd0, words_loaded}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t7_ready", {31'd0, byte_ready}, 32'd1);
    chk("t7_wr_en", {31'd0, imem_wr_en}, 32'd0);
    chk("t7_addr",  {20'd0, imem_wr_addr}, 32'd0);
    chk("t7_data",  imem_wr_data, 32'd0);
    chk("t7_hold",  {31'd0, cpu_hold}, 32'd1);
    chk("t7_words", {19'd0, words_loaded}, 32'd0);
    chk("t7_done",  {31'd0, load_done}, 32'd0);
    chk("t7_err",   {31'd0, load_err}, 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    wa.delete();
    wd.delete();
    send(8'hA5, 0);
    send_ref_body(0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'h25, 0);
`endif
    tick(2);
    chk("t7_done_after", {31'd0, load_done}, 32'd1);
    chk("t7_words_after", {19'd0, words_loaded}, 32'd2);
    check_ref_writes("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
